// File: rtl/ysyx_24080014_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: immediate classes, opcodes,
// FSM state encodings and the decoder result bundle.
package ysyx_24080014_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    IMM_R   = 3'b000,
    IMM_I   = 3'b001,
    IMM_S   = 3'b010,
    IMM_U   = 3'b011,
    IMM_B   = 3'b100,
    IMM_J   = 3'b101,
    IMM_ERR = 3'b110
  } imm_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_IWAIT,
    ST_DECODE,
    ST_MEM,
    ST_MWAIT,
    ST_WB,
    ST_STOP
  } state_e;

  typedef struct packed {
    imm_type_e imm_type;
    logic      is_mem;
    logic      is_store;
    logic      no_rf_wr;
  } dec_t;

endpackage

// File: rtl/ysyx_24080014_mc_ctrl_if.sv
// IFU and LSU request/response handshakes seen by the sequencer.
interface ysyx_24080014_mc_ctrl_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        lsu_req_valid;
  logic        lsu_req_we;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;

  modport master (
    output ifu_req_valid,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst,
    output lsu_req_valid,
    output lsu_req_we,
    input  lsu_req_ready,
    input  lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst,
    input  lsu_req_valid,
    input  lsu_req_we,
    output lsu_req_ready,
    output lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_24080014_opc_dec.sv
// Combinational opcode classifier: immediate class plus memory/writeback attributes.
module ysyx_24080014_opc_dec
  import ysyx_24080014_mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '{imm_type: IMM_ERR, is_mem: 1'b0, is_store: 1'b0, no_rf_wr: 1'b0};
    case (opcode)
      OPC_OP:                                 dec.imm_type = IMM_R;
      OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:       dec.imm_type = IMM_I;
      OPC_LOAD: begin
        dec.imm_type = IMM_I;
        dec.is_mem   = 1'b1;
      end
      OPC_STORE: begin
        dec.imm_type = IMM_S;
        dec.is_mem   = 1'b1;
        dec.is_store = 1'b1;
        dec.no_rf_wr = 1'b1;
      end
      OPC_LUI, OPC_AUIPC:                     dec.imm_type = IMM_U;
      OPC_BRANCH: begin
        dec.imm_type = IMM_B;
        dec.no_rf_wr = 1'b1;
      end
      OPC_JAL:                                dec.imm_type = IMM_J;
      default:                                dec.imm_type = IMM_ERR;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_mc_ctrl.sv
// Multi-cycle core sequencer: fetch, latch, decode, optional LSU access, commit.
module ysyx_24080014_mc_ctrl
  import ysyx_24080014_mc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_24080014_mc_ctrl_if.master    bus,
  output logic [31:0]                pc,
  input  logic [31:0]                next_pc,
  output logic [31:0]                inst,
  output logic [2:0]                 imm_type,
  output logic                       pc_we,
  output logic                       rf_we,
  output logic                       halt,
  output logic                       err
);

  state_e      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  imm_type_e   imm_reg, imm_next;
  logic        halt_reg, halt_next;
  logic        err_reg, err_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        ifu_req, lsu_req, lsu_we;
  dec_t        dec;

  // The latched instruction is stable from DECODE onward, so one decoder serves every state.
  ysyx_24080014_opc_dec u_opc_dec (
    .opcode (inst_reg[6:0]),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
      imm_reg   <= IMM_R;
      halt_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      imm_reg   <= imm_next;
      halt_reg  <= halt_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    imm_next   = imm_reg;
    halt_next  = halt_reg;
    err_next   = err_reg;
    ifu_req    = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        ifu_req = 1'b1;
        if (bus.ifu_req_ready) state_next = ST_IWAIT;
      end
      ST_IWAIT: begin
        if (bus.ifu_rsp_valid) begin
          inst_next  = bus.ifu_rsp_inst;
          state_next = ST_DECODE;
        end else if (cnt_reg == WAIT_LIMIT - 8'd1) begin
          err_next   = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_DECODE: begin
        imm_next = dec.imm_type;
        if (dec.imm_type == IMM_ERR) begin
          err_next   = 1'b1;
          state_next = ST_STOP;
        end else if (inst_reg == EBREAK) begin
          halt_next  = 1'b1;
          state_next = ST_STOP;
        end else if (dec.is_mem) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = dec.is_store;
        if (bus.lsu_req_ready) state_next = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (bus.lsu_rsp_valid) begin
          state_next = ST_WB;
        end else if (cnt_reg == WAIT_LIMIT - 8'd1) begin
          err_next   = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_WB: begin
        pc_we      = 1'b1;
        rf_we      = ~dec.no_rf_wr;
        pc_next    = next_pc;
        state_next = ST_FETCH;
      end
      ST_STOP: ;
      default: state_next = ST_FETCH;
    endcase
  end

  // Wait counter restarts on any state change and only advances while parked in a wait state.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg)
      cnt_next = 8'd0;
    else if (state_reg == ST_IWAIT || state_reg == ST_MWAIT)
      cnt_next = cnt_reg + 8'd1;
  end

  assign bus.ifu_req_valid = ifu_req;
  assign bus.lsu_req_valid = lsu_req;
  assign bus.lsu_req_we    = lsu_we;
  assign pc                = pc_reg;
  assign inst              = inst_reg;
  assign imm_type          = imm_reg;
  assign halt              = halt_reg;
  assign err               = err_reg;

endmodule

// File: tb/tb_ysyx_24080014_mc_ctrl.sv
// Directed bench for the multi-cycle sequencer; inputs change 1ns after each rising edge.
module tb_ysyx_24080014_mc_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, next_pc, inst;
  logic [2:0]  imm_type;
  logic        pc_we, rf_we, halt, err;
  int          n_cmp = 0;
  int          n_err = 0;

  ysyx_24080014_mc_ctrl_if bus ();

  ysyx_24080014_mc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pc       (pc),
    .next_pc  (next_pc),
    .inst     (inst),
    .imm_type (imm_type),
    .pc_we    (pc_we),
    .rf_we    (rf_we),
    .halt     (halt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // From FETCH: accept the request, answer in IWAIT; returns with the FSM in DECODE.
  task automatic fetch(input logic [31:0] word);
    bus.ifu_req_ready = 1'b1;
    tick();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_inst  = word;
    tick();
    bus.ifu_rsp_valid = 1'b0;
    chk_eq("inst_latched", inst, word);
  endtask

  logic [31:0] seq_inst [3];
  logic [2:0]  seq_imm  [3];
  logic        seq_rf   [3];

  initial begin
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_inst  = 32'h0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    next_pc = 32'h0;
    seq_inst[0] = 32'h0000_00b7; seq_imm[0] = 3'b011; seq_rf[0] = 1'b1;
    seq_inst[1] = 32'h0000_0063; seq_imm[1] = 3'b100; seq_rf[1] = 1'b0;
    seq_inst[2] = 32'h0000_006f; seq_imm[2] = 3'b101; seq_rf[2] = 1'b1;

    // Reset values
    tick();
    chk_eq("rst_pc", pc, RST_PC);
    chk_eq("rst_inst", inst, 32'h0);
    chk_eq("rst_imm", {29'h0, imm_type}, 32'h0);
    chk_eq("rst_strobes", {28'h0, pc_we, rf_we, halt, err}, 32'h0);
    tick();
    rst = 1'b0;
    chk_eq("rst_fetch_req", {31'h0, bus.ifu_req_valid}, 32'h1);

    // addi: four-cycle commit
    next_pc = 32'h8000_0004;
    fetch(32'h0010_0093);
    tick();
    chk_eq("addi_imm", {29'h0, imm_type}, 32'h1);
    chk_eq("addi_pc_we", {31'h0, pc_we}, 32'h1);
    chk_eq("addi_rf_we", {31'h0, rf_we}, 32'h1);
    chk_eq("addi_pc_hold", pc, RST_PC);
    tick();
    chk_eq("addi_pc_we_off", {30'h0, pc_we, rf_we}, 32'h0);
    chk_eq("addi_pc", pc, 32'h8000_0004);
    $display("txn addi pc=%h", pc);

    // store with LSU back-pressure
    next_pc = 32'h8000_0008;
    fetch(32'h0020_a023);
    tick();
    chk_eq("st_imm", {29'h0, imm_type}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      chk_eq("st_req_hold", {30'h0, bus.lsu_req_valid, bus.lsu_req_we}, 32'h3);
      if (i < 2) tick();
    end
    bus.lsu_req_ready = 1'b1;
    tick();
    bus.lsu_req_ready = 1'b0;
    chk_eq("st_req_drop", {31'h0, bus.lsu_req_valid}, 32'h0);
    tick();
    bus.lsu_rsp_valid = 1'b1;
    tick();
    bus.lsu_rsp_valid = 1'b0;
    chk_eq("st_wb", {30'h0, pc_we, rf_we}, 32'h2);
    tick();
    chk_eq("st_pc", pc, 32'h8000_0008);
    $display("txn store pc=%h", pc);

    // load: read request, writes the regfile
    next_pc = 32'h8000_000c;
    fetch(32'h0000_a083);
    tick();
    chk_eq("ld_req", {30'h0, bus.lsu_req_valid, bus.lsu_req_we}, 32'h2);
    bus.lsu_req_ready = 1'b1;
    tick();
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    tick();
    bus.lsu_rsp_valid = 1'b0;
    chk_eq("ld_wb", {30'h0, pc_we, rf_we}, 32'h3);
    chk_eq("ld_imm", {29'h0, imm_type}, 32'h1);
    tick();
    $display("txn load pc=%h", pc);

    // lui / beq / jal
    for (int k = 0; k < 3; k++) begin
      next_pc = 32'h8000_0010 + 32'(k * 4);
      fetch(seq_inst[k]);
      tick();
      chk_eq("seq_imm", {29'h0, imm_type}, {29'h0, seq_imm[k]});
      chk_eq("seq_wb", {30'h0, pc_we, rf_we}, {30'h0, 1'b1, seq_rf[k]});
      tick();
      chk_eq("seq_pc", pc, 32'h8000_0010 + 32'(k * 4));
      $display("txn seq inst=%h imm=%b rf_we_exp=%0d", seq_inst[k], imm_type, seq_rf[k]);
    end

    // reset inside MWAIT, then a stale LSU response
    fetch(32'h0000_a083);
    tick();
    bus.lsu_req_ready = 1'b1;
    tick();
    bus.lsu_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("mrst_pc", pc, RST_PC);
    chk_eq("mrst_inst", inst, 32'h0);
    chk_eq("mrst_fetch", {31'h0, bus.ifu_req_valid}, 32'h1);
    tick();
    rst = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    tick();
    bus.lsu_rsp_valid = 1'b0;
    chk_eq("mrst_no_commit", {30'h0, pc_we, rf_we}, 32'h0);
    chk_eq("mrst_still_fetch", {30'h0, bus.ifu_req_valid, bus.lsu_req_valid}, 32'h2);
    chk_eq("mrst_pc_after", pc, RST_PC);
    $display("txn reset_in_mwait pc=%h", pc);

    // response on the last IWAIT cycle before timeout
    next_pc = 32'h8000_0100;
    bus.ifu_req_ready = 1'b1;
    tick();
    bus.ifu_req_ready = 1'b0;
    repeat (254) tick();
    chk_eq("late_rsp_err_before", {31'h0, err}, 32'h0);
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_inst  = 32'h0010_0093;
    tick();
    bus.ifu_rsp_valid = 1'b0;
    chk_eq("late_rsp_inst", inst, 32'h0010_0093);
    tick();
    chk_eq("late_rsp_wb", {30'h0, pc_we, err}, 32'h2);
    tick();
    chk_eq("late_rsp_pc", pc, 32'h8000_0100);
    $display("txn iwait_254 pc=%h", pc);

    // response withheld: timeout
    bus.ifu_req_ready = 1'b1;
    tick();
    bus.ifu_req_ready = 1'b0;
    repeat (254) tick();
    chk_eq("tmo_not_yet", {31'h0, err}, 32'h0);
    tick();
    chk_eq("tmo_err", {31'h0, err}, 32'h1);
    repeat (3) tick();
    chk_eq("tmo_stopped", {30'h0, bus.ifu_req_valid, pc_we}, 32'h0);
    chk_eq("tmo_pc", pc, 32'h8000_0100);
    $display("txn timeout err=%0d", err);

    // illegal opcode
    do_reset();
    chk_eq("ill_err_clear", {31'h0, err}, 32'h0);
    fetch(32'h0000_007f);
    tick();
    chk_eq("ill_imm", {29'h0, imm_type}, 32'h6);
    chk_eq("ill_err", {31'h0, err}, 32'h1);
    chk_eq("ill_no_pc_we", {31'h0, pc_we}, 32'h0);
    repeat (5) tick();
    chk_eq("ill_stopped", {29'h0, bus.ifu_req_valid, pc_we, err}, 32'h1);
    chk_eq("ill_pc", pc, RST_PC);
    $display("txn illegal err=%0d", err);

    // ebreak
    do_reset();
    fetch(32'h0010_0073);
    tick();
    chk_eq("ebrk_halt", {30'h0, halt, err}, 32'h2);
    chk_eq("ebrk_quiet", {28'h0, pc_we, rf_we, bus.ifu_req_valid, bus.lsu_req_valid}, 32'h0);
    repeat (4) tick();
    chk_eq("ebrk_stay", {29'h0, halt, bus.ifu_req_valid, pc_we}, 32'h4);
    chk_eq("ebrk_pc", pc, RST_PC);
    $display("txn ebreak halt=%0d", halt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
